vector_serializer: RTL and testbench

Transmit-side counterpart of the bit-to-vector buffer: accepts 8-bit vectors from a producer over a valid/ready handshake, holds up to `NB_VECTORS` of them in a ring buffer, and serves them back out one bit per request, MSB first. The bit order matches the receive-side buffer, which shifts bits in from the LSB, so a vector sent through this block and collected by the receiver arrives unchanged. Sits between the vector-producing datapath and the serial bit link.

---
 rtl/vector_serializer_pkg.sv | 18 +
 rtl/vector_serializer_chk.sv | 27 ++
 rtl/vector_serializer.sv | 107 ++++++++++
 tb/tb_vector_serializer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vector_serializer_pkg.sv
// Constants shared by the transmit-side serializer and the receive-side
// bit-to-vector buffer, plus the MSB-first bit selection helper.
package vector_serializer_pkg;

  localparam int VEC_W     = 8;
  localparam int BIT_IDX_W = $clog2(VEC_W);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(VEC_W - 1);

  // Bit sent at position idx when a vector goes out MSB first.
  function automatic logic msb_first_bit(input logic [VEC_W-1:0]     vec,
                                         input logic [BIT_IDX_W-1:0] idx);
    logic [BIT_IDX_W-1:0] pos;
    pos = LAST_IDX - idx;
    return vec[pos];
  endfunction

endpackage

// File: rtl/vector_serializer_chk.sv
// Structural invariants of the serializer ring, observed on its internal
// occupancy, bit index and ready flag.
module vector_serializer_chk
  import vector_serializer_pkg::*;
#(
  parameter int NB_VECTORS = 8
) (
  input logic                        clk_i,
  input logic                        rst_n_i,
  input logic [$clog2(NB_VECTORS):0] count_i,
  input logic [BIT_IDX_W-1:0]        idx_i,
  input logic                        vector_ready_i
);

  localparam int CNT_W = $clog2(NB_VECTORS) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NB_VECTORS);

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    count_i <= FULL_CNT);

  a_ready_decode: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    vector_ready_i == (count_i != FULL_CNT));

  a_idle_idx: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (count_i == {CNT_W{1'b0}}) |-> (idx_i == {BIT_IDX_W{1'b0}}));

endmodule

// File: rtl/vector_serializer.sv
// Ring buffer of VEC_W-bit vectors filled over valid/ready and drained one
// bit per request, MSB first, to match the LSB-shifting receive buffer.
module vector_serializer
  import vector_serializer_pkg::*;
#(
  parameter int NB_VECTORS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [VEC_W-1:0]              vector_in,
  input  logic                          vector_valid,
  output logic                          vector_ready,
  input  logic                          bit_req,
  output logic                          output_bit,
  output logic                          bit_valid,
  output logic [$clog2(NB_VECTORS):0]   level
);

  localparam int PTR_W = $clog2(NB_VECTORS);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NB_VECTORS);

  logic [VEC_W-1:0]     ring_q [NB_VECTORS];
  logic [PTR_W-1:0]     prod_q, prod_d;
  logic [PTR_W-1:0]     cons_q, cons_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d;
  logic                 out_bit_q, out_bit_d;
  logic                 bit_valid_q, bit_valid_d;

  logic push_s;
  logic pop_s;
  logic last_s;

  // Handshake and pop qualifiers, all from pre-edge registered state.
  assign vector_ready = (count_q != FULL_CNT);
  assign push_s       = vector_valid & vector_ready;
  assign pop_s        = bit_req & (count_q != {CNT_W{1'b0}});
  assign last_s       = pop_s & (idx_q == LAST_IDX);

  assign output_bit = out_bit_q;
  assign bit_valid  = bit_valid_q;
  assign level      = count_q;

  // Next-state for pointers, occupancy, bit index and the served bit.
  always_comb begin
    prod_d      = prod_q;
    cons_d      = cons_q;
    count_d     = count_q;
    idx_d       = idx_q;
    out_bit_d   = 1'b0;
    bit_valid_d = 1'b0;

    if (pop_s) begin
      out_bit_d   = msb_first_bit(ring_q[cons_q], idx_q);
      bit_valid_d = 1'b1;
      idx_d       = idx_q + BIT_IDX_W'(1);
      if (last_s) begin
        cons_d = cons_q + PTR_W'(1);
      end else begin
        cons_d = cons_q;
      end
    end else begin
      idx_d = idx_q;
    end

    if (push_s) begin
      prod_d = prod_q + PTR_W'(1);
    end else begin
      prod_d = prod_q;
    end

    // A push and a final-bit pop together leave occupancy unchanged.
    case ({push_s, last_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q      <= {PTR_W{1'b0}};
      cons_q      <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      idx_q       <= {BIT_IDX_W{1'b0}};
      out_bit_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      cons_q      <= cons_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      out_bit_q   <= out_bit_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  // Vector storage; contents after reset are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ring_q[prod_q] <= vector_in;
    end
  end

endmodule

// File: tb/tb_vector_serializer.sv
// Randomized scoreboard bench: a queue-of-vectors model predicts every cycle,
// and a monitor reassembles served bits like the receive-side buffer.
module tb_vector_serializer;

  localparam int NB = 8;
  localparam int CW = $clog2(NB) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    vector_in;
  logic          vector_valid;
  logic          vector_ready;
  logic          bit_req;
  logic          output_bit;
  logic          bit_valid;
  logic [CW-1:0] level;

  int checks   = 0;
  int failures = 0;

  // Model state: stored vectors in order, bits of the head already sent.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  int         msent   = 0;
  logic       exp_valid = 1'b0;
  logic       exp_bit   = 1'b0;
  logic       started   = 1'b0;

  // Receive-side reassembly state.
  logic [7:0] rx = 8'h00;
  int         rx_cnt = 0;

  always #5 clk = ~clk;

  vector_serializer #(.NB_VECTORS(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vector_in    (vector_in),
    .vector_valid (vector_valid),
    .vector_ready (vector_ready),
    .bit_req      (bit_req),
    .output_bit   (output_bit),
    .bit_valid    (bit_valid),
    .level        (level)
  );

  vector_serializer_chk #(.NB_VECTORS(NB)) u_chk (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .count_i        (dut.count_q),
    .idx_i          (dut.idx_q),
    .vector_ready_i (dut.vector_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pop decided on the pre-edge count, then push appended.
  always @(posedge clk) begin
    int         n;
    logic [7:0] v;
    started <= 1'b1;
    if (!rst_n) begin
      mq.delete();
      sb.delete();
      msent     = 0;
      exp_valid = 1'b0;
      exp_bit   = 1'b0;
      rx_cnt    = 0;
    end else begin
      n         = mq.size();
      exp_valid = 1'b0;
      exp_bit   = 1'b0;
      if (bit_req && n != 0) begin
        v         = mq[0];
        exp_bit   = v[7 - msent];
        exp_valid = 1'b1;
        msent++;
        if (msent == 8) begin
          void'(mq.pop_front());
          msent = 0;
        end
      end
      if (vector_valid && n != NB) begin
        mq.push_back(vector_in);
        sb.push_back(vector_in);
      end
    end
  end

  // Monitor: per-cycle outputs, plus whole-vector scoreboard on reassembly.
  always @(negedge clk) begin
    if (started) begin
      chk("bit_valid", int'(bit_valid), int'(exp_valid));
      if (exp_valid) chk("output_bit", int'(output_bit), int'(exp_bit));
      chk("level", int'(level), mq.size());
      chk("vector_ready", int'(vector_ready), int'(mq.size() != NB));
      if (bit_valid) begin
        rx = {rx[6:0], output_bit};
        rx_cnt++;
        if (rx_cnt == 8) begin
          rx_cnt = 0;
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            chk("vector", int'(rx), int'(sb.pop_front()));
          end
        end
      end
    end
  end

  task automatic drive(input logic rn, input logic v, input logic [7:0] d,
                       input logic r);
    rst_n = rn; vector_valid = v; vector_in = d; bit_req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    int         pushed;
    logic       v, r, acc;

    rst_n = 1'b0; vector_valid = 1'b0; vector_in = 8'h00; bit_req = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(vector_ready), 1);
    chk("rst_bit_valid", int'(bit_valid), 0);

    // 0xA5 served MSB first, then one request on an empty ring.
    drive(1'b1, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);
    chk("a5_level", int'(level), 0);

    // Fill, then a rejected push of 0xFF.
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1, 8'(i), 1'b0);
    chk("full_level", int'(level), 8);
    chk("full_ready", int'(vector_ready), 0);
    drive(1'b1, 1'b1, 8'hFF, 1'b0);
    chk("ff_ignored_level", int'(level), 8);

    // Continuous drain with a waiting producer: 16 refills across the wrap.
    pushed = 0;
    nxt    = 8'h09;
    while (pushed < 16) begin
      acc = (mq.size() != NB);
      drive(1'b1, 1'b1, nxt, 1'b1);
      if (acc) begin
        pushed++;
        nxt = nxt + 8'h01;
      end
    end
    for (int i = 0; i < NB * 8 + 4; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);
    chk("drain_level", int'(level), 0);

    // Push into empty ring with a same-cycle request.
    drive(1'b1, 1'b1, 8'h80, 1'b1);
    chk("empty_req_dropped", int'(bit_valid), 0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    chk("first_bit_after_push", int'(output_bit), 1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);

    // Reset part-way through 0xF0, then 0x0F from its MSB.
    drive(1'b1, 1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("midrst_level", int'(level), 0);
    chk("midrst_bit_valid", int'(bit_valid), 0);
    chk("midrst_ready", int'(vector_ready), 1);
    drive(1'b1, 1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);

    // Random loopback; the producer holds its vector until accepted.
    cur = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 3) != 0);
      acc = v && (mq.size() != NB);
      if ($urandom_range(0, 599) == 0) begin
        drive(1'b0, v, cur, r);
      end else begin
        drive(1'b1, v, cur, r);
        if (acc) cur = 8'($urandom);
      end
    end
    for (int i = 0; i < NB * 8 + 4; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);
    chk("final_level", int'(level), 0);
    chk("sb_empty", sb.size(), 0);
    chk("rx_partial", rx_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
